// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble steps for a given operand width; 0 flags an illegal width
    // so the instantiating module can refuse to elaborate.
    function automatic int num_nib(input int width);
        if (width < NIB_W || (width % NIB_W) != 0) begin
            return 0;
        end
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/rca4_slice.sv
// Combinational 4-bit ripple-carry adder slice built from four full-adder cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: a, b (4-bit addends), cin (carry in), s (4-bit sum), cout (carry out).
module rca4_slice
    import serial_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit adder that steps one shared 4-bit slice over the nibbles, LSB first.
// Latency: accept at edge T, result valid after edge T+NUM_NIB; one result per NUM_NIB+2 cycles.
// Backpressure: result (sum/cout) held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk/rst_n (async active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NUM_NIB = num_nib(WIDTH);
    localparam int K_W     = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

    if (NUM_NIB == 0) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               carry;
    logic [K_W-1:0]     k;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;

    // Operands shift right each step, so the slice always reads the low nibble.
    rca4_slice u_slice (
        .a    (opa[NIB_W-1:0]),
        .b    (opb[NIB_W-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_co)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        k     <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_NIB; i++) begin
                        if (k == K_W'(i)) begin
                            sum[i*NIB_W +: NIB_W] <= slice_s;
                        end
                    end
                    carry <= slice_co;
                    opa   <= opa >> NIB_W;
                    opb   <= opb >> NIB_W;
                    if (k == K_W'(NUM_NIB - 1)) begin
                        cout  <= slice_co;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
